// File: rtl/mk_design_gen.sv
// Iterative shift-add multiplier (unsigned or signed) feeding a DEPTH-entry result FIFO.
// Define MK_DESIGN_GEN_EARLY_EXIT_EN to end BUSY once the remaining multiplier bits are zero.
module mk_design_gen #(
    parameter int unsigned W      = 8,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned SIGNED = 0
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [W-1:0] start_a,
    input  logic [W-1:0] start_b,
    input  logic         EN_start,
    output logic         RDY_start,
    output logic [W-1:0] resresult_,
    output logic         RDY_result,
    input  logic         EN_check,
    output logic [W-1:0] chresult_,
    output logic         RDY_check
);

    localparam int unsigned CNTW = $clog2(W + 1);
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW   = $clog2(DEPTH + 1);
    localparam logic [2*W-1:0] One2 = {{(2*W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state;
    logic [2*W-1:0]    mcand;
    logic [2*W-1:0]    acc;
    logic [2*W-1:0]    prod;
    logic [W-1:0]      mplier;
    logic [W-1:0]      a_mag;
    logic [W-1:0]      b_mag;
    logic [CNTW-1:0]   iter;
    logic              neg;
    logic              sign_in;
    logic              last;
    logic              can_accept;
    logic              accept;
    logic              push;
    logic              pop;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic [2*W-1:0]    mem [DEPTH];
    logic [2*W-1:0]    head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Signed mode multiplies magnitudes; the most-negative value maps to 2^(W-1) unsigned.
    always_comb begin
        a_mag   = start_a;
        b_mag   = start_b;
        sign_in = 1'b0;
        if (SIGNED != 0) begin
            if (start_a[W-1]) a_mag = ~start_a + W'(1);
            if (start_b[W-1]) b_mag = ~start_b + W'(1);
            sign_in = start_a[W-1] ^ start_b[W-1];
        end
    end

    always_comb begin
`ifdef MK_DESIGN_GEN_EARLY_EXIT_EN
        last = (iter == CNTW'(1)) || ((mplier >> 1) == '0);
`else
        last = (iter == CNTW'(1));
`endif
    end

    // The FIFO slot is reserved at accept time, so a DONE write always has room.
    assign can_accept = (state == StIdle) && (count < CW'(DEPTH));
    assign accept     = can_accept && EN_start;
    assign push       = (state == StDone);
    assign pop        = EN_check && (count != '0);
    assign prod       = neg ? (~acc + One2) : acc;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= StIdle;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            iter   <= '0;
            neg    <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (accept) begin
                        mcand  <= {{W{1'b0}}, a_mag};
                        mplier <= b_mag;
                        acc    <= '0;
                        iter   <= CNTW'(W);
                        neg    <= sign_in;
                        state  <= StBusy;
                    end
                end
                StBusy: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    iter   <= iter - CNTW'(1);
                    if (last) state <= StDone;
                end
                StDone:  state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= prod;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (!push && pop) begin
                count <= count - CW'(1);
            end
        end
    end

    assign head       = mem[rd_ptr];
    assign RDY_start  = can_accept;
    assign RDY_result = (count != '0);
    assign RDY_check  = RDY_result;
    assign resresult_ = RDY_result ? head[W-1:0]   : '0;
    assign chresult_  = RDY_result ? head[2*W-1:W] : '0;

endmodule

// File: tb/tb_mk_design_gen.sv
// Directed bench: unsigned DEPTH=2, signed DEPTH=2 and unsigned DEPTH=1 instances of mk_design_gen.
module tb_mk_design_gen;

`ifdef MK_DESIGN_GEN_EARLY_EXIT_EN
    localparam int LatB1 = 2;
    localparam int LatB0 = 2;
`else
    localparam int LatB1 = 9;
    localparam int LatB0 = 9;
`endif

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] a [3];
    logic [7:0] b [3];
    logic [7:0] res [3];
    logic [7:0] ch [3];
    logic       en_s [3];
    logic       en_c [3];
    logic       rdy_s [3];
    logic       rdy_r [3];
    logic       rdy_c [3];
    int         n_tests = 0;
    int         n_fail = 0;
    int         lat;

    always #5 CLK = ~CLK;

    mk_design_gen #(.W(8), .DEPTH(2), .SIGNED(0)) u_uns (
        .CLK(CLK), .RST(RST), .start_a(a[0]), .start_b(b[0]), .EN_start(en_s[0]),
        .RDY_start(rdy_s[0]), .resresult_(res[0]), .RDY_result(rdy_r[0]),
        .EN_check(en_c[0]), .chresult_(ch[0]), .RDY_check(rdy_c[0])
    );

    mk_design_gen #(.W(8), .DEPTH(2), .SIGNED(1)) u_sgn (
        .CLK(CLK), .RST(RST), .start_a(a[1]), .start_b(b[1]), .EN_start(en_s[1]),
        .RDY_start(rdy_s[1]), .resresult_(res[1]), .RDY_result(rdy_r[1]),
        .EN_check(en_c[1]), .chresult_(ch[1]), .RDY_check(rdy_c[1])
    );

    mk_design_gen #(.W(8), .DEPTH(1), .SIGNED(0)) u_d1 (
        .CLK(CLK), .RST(RST), .start_a(a[2]), .start_b(b[2]), .EN_start(en_s[2]),
        .RDY_start(rdy_s[2]), .resresult_(res[2]), .RDY_result(rdy_r[2]),
        .EN_check(en_c[2]), .chresult_(ch[2]), .RDY_check(rdy_c[2])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic start_op(input int k, input logic [7:0] av, input logic [7:0] bv);
        int n = 0;
        while (!rdy_s[k] && n < 40) begin
            idle(1);
            n++;
        end
        check_eq("start_ready", 32'(rdy_s[k]), 32'd1);
        a[k]    = av;
        b[k]    = bv;
        en_s[k] = 1'b1;
        idle(1);
        en_s[k] = 1'b0;
    endtask

    task automatic wait_result(input int k, input string tag, output int l);
        l = 0;
        while (!rdy_r[k] && l < 40) begin
            idle(1);
            l++;
        end
        check_eq(tag, 32'(rdy_r[k]), 32'd1);
    endtask

    task automatic deq_check(input int k, input string tag, input logic [15:0] exp);
        check_eq(tag, {16'd0, ch[k], res[k]}, {16'd0, exp});
        en_c[k] = 1'b1;
        idle(1);
        en_c[k] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a[i] = '0; b[i] = '0; en_s[i] = 1'b0; en_c[i] = 1'b0;
        end
        idle(2);
        RST = 1'b0;

        check_eq("rst_rdy_start", 32'(rdy_s[0]), 32'd1);
        check_eq("rst_rdy_result", 32'(rdy_r[0]), 32'd0);
        check_eq("rst_rdy_check", 32'(rdy_c[0]), 32'd0);
        check_eq("rst_resresult", 32'(res[0]), 32'd0);
        check_eq("rst_chresult", 32'(ch[0]), 32'd0);

        // 0xFF * 0xFF, fixed latency in both builds (top bit of b set)
        start_op(0, 8'hFF, 8'hFF);
        wait_result(0, "ff_done", lat);
        check_eq("ff_latency", 32'(lat), 32'd9);
        deq_check(0, "ff_x_ff", 16'hFE01);
        check_eq("ff_empty", 32'(rdy_c[0]), 32'd0);

        // dequeue on empty is ignored
        en_c[0] = 1'b1;
        idle(1);
        en_c[0] = 1'b0;
        check_eq("empty_deq_check", 32'(rdy_c[0]), 32'd0);
        check_eq("empty_deq_start", 32'(rdy_s[0]), 32'd1);

        // fill DEPTH=2, third start must wait for a slot
        start_op(0, 8'd3, 8'd5);
        start_op(0, 8'd7, 8'd9);
        idle(12);
        check_eq("full_rdy_start", 32'(rdy_s[0]), 32'd0);
        check_eq("full_rdy_check", 32'(rdy_c[0]), 32'd1);
        deq_check(0, "fifo_0", 16'h000F);
        check_eq("slot_freed", 32'(rdy_s[0]), 32'd1);
        start_op(0, 8'd2, 8'd2);
        idle(12);
        deq_check(0, "fifo_1", 16'h003F);
        deq_check(0, "fifo_2", 16'h0004);
        check_eq("fifo_empty", 32'(rdy_c[0]), 32'd0);

        // latency vs multiplier value
        start_op(0, 8'h5A, 8'h01);
        wait_result(0, "b1_done", lat);
        check_eq("b1_latency", 32'(lat), 32'(LatB1));
        deq_check(0, "b1_prod", 16'h005A);
        start_op(0, 8'h5A, 8'h00);
        wait_result(0, "b0_done", lat);
        check_eq("b0_latency", 32'(lat), 32'(LatB0));
        deq_check(0, "b0_prod", 16'h0000);
        start_op(0, 8'h5A, 8'h80);
        wait_result(0, "b80_done", lat);
        check_eq("b80_latency", 32'(lat), 32'd9);
        deq_check(0, "b80_prod", 16'h2D00);

        // DONE write and dequeue on the same edge
        start_op(0, 8'd1, 8'd1);
        wait_result(0, "sim_first", lat);
        start_op(0, 8'h10, 8'hFF);
        idle(8);
        deq_check(0, "sim_old_head", 16'h0001);
        check_eq("sim_count", 32'(rdy_c[0]), 32'd1);
        check_eq("sim_rdy_start", 32'(rdy_s[0]), 32'd1);
        deq_check(0, "sim_new_head", 16'h0FF0);
        check_eq("sim_empty", 32'(rdy_c[0]), 32'd0);

        // signed instance
        start_op(1, 8'hFD, 8'h05);
        wait_result(1, "s_m3x5_done", lat);
        deq_check(1, "s_m3x5", 16'hFFF1);
        start_op(1, 8'h80, 8'h80);
        wait_result(1, "s_min_done", lat);
        deq_check(1, "s_min_x_min", 16'h4000);
        start_op(1, 8'h7F, 8'h81);
        wait_result(1, "s_mixed_done", lat);
        deq_check(1, "s_127x_m127", 16'hC0FF);

        // DEPTH=1 instance
        start_op(2, 8'd2, 8'd3);
        wait_result(2, "d1_done", lat);
        check_eq("d1_full", 32'(rdy_s[2]), 32'd0);
        a[2] = 8'd9; b[2] = 8'd9; en_s[2] = 1'b1;
        idle(1);
        en_s[2] = 1'b0;
        idle(12);
        check_eq("d1_ignored_start", 32'(rdy_c[2]), 32'd1);
        deq_check(2, "d1_head", 16'h0006);
        check_eq("d1_nodup", 32'(rdy_c[2]), 32'd0);
        start_op(2, 8'd4, 8'd5);
        wait_result(2, "d1_second_done", lat);
        deq_check(2, "d1_second", 16'h0014);

        // reset in the middle of BUSY
        start_op(0, 8'd9, 8'd9);
        idle(3);
        RST = 1'b1;
        idle(1);
        RST = 1'b0;
        check_eq("mid_rst_rdy_start", 32'(rdy_s[0]), 32'd1);
        check_eq("mid_rst_rdy_result", 32'(rdy_r[0]), 32'd0);
        idle(15);
        check_eq("mid_rst_no_stale", 32'(rdy_r[0]), 32'd0);
        start_op(0, 8'd9, 8'd9);
        wait_result(0, "post_rst_done", lat);
        deq_check(0, "post_rst_prod", 16'h0051);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
